// File: rtl/temp_entry_ctrl.sv
// temp_entry_ctrl: PS/2 two-digit setpoint entry with break/extended filtering; TEMP_ENTRY_TIMEOUT_EN adds an idle timeout
module temp_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int TO_W = 27
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] scan_code,
  output logic [7:0] decenas,
  output logic [7:0] unidades,
  output logic       bandera,
  output logic       busy,
  output logic [1:0] digit_count,
  output logic       error
);
  typedef enum logic [1:0] {IDLE, TENS, UNITS, LOAD} state_t;
  state_t r_state, w_next;
  logic r_brk, r_ext, r_band, r_err;
  logic [7:0] r_dec, r_uni;
  logic w_key, w_digit, w_enter, w_bksp, w_reject, w_to_exp;
  if (2**TO_W <= TIMEOUT_CYCLES) begin : g_bad_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end
  assign w_key   = rx_done_tick && !r_brk && !r_ext && scan_code != 8'hF0 && scan_code != 8'hE0;
  assign w_digit = scan_code inside {8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  assign w_enter = scan_code == 8'h5A;
  assign w_bksp  = scan_code == 8'h66;
  assign decenas  = r_dec;
  assign unidades = r_uni;
  assign bandera  = r_band;
  assign error    = r_err;
  // prefix filter: F0 swallows one byte, E0 swallows through the first non-F0 byte
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_brk <= 1'b0;
      r_ext <= 1'b0;
    end else if (rx_done_tick) begin
      if (r_ext) r_ext <= scan_code == 8'hF0;
      else if (r_brk) r_brk <= 1'b0;
      else begin
        r_brk <= scan_code == 8'hF0;
        r_ext <= scan_code == 8'hE0;
      end
    end
`ifdef TEMP_ENTRY_TIMEOUT_EN
  logic [TO_W-1:0] r_to;
  assign w_to_exp = busy && !rx_done_tick && r_to == TO_W'(TIMEOUT_CYCLES - 1);
  // idle timer: counts quiet cycles mid-entry, any received byte restarts it
  always_ff @(posedge CLK or posedge reset)
    if (reset) r_to <= '0;
    else r_to <= (!busy || rx_done_tick || w_to_exp) ? '0 : r_to + 1'b1;
`else
  assign w_to_exp = 1'b0;
`endif
  // state register
  always_ff @(posedge CLK or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // next-state logic; keys arriving in LOAD are dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_key && w_digit) ? TENS : IDLE;
      TENS:    if (w_key) w_next = w_digit ? UNITS : w_enter ? LOAD : w_bksp ? IDLE : TENS;
      UNITS:   if (w_key) w_next = w_enter ? LOAD : w_bksp ? TENS : UNITS;
      default: w_next = IDLE;
    endcase
    if (w_to_exp) w_next = IDLE;
  end
  // state-decoded outputs and key rejection
  always_comb begin
    busy        = r_state == TENS || r_state == UNITS;
    digit_count = r_state == TENS ? 2'd1 : r_state == UNITS ? 2'd2 : 2'd0;
    w_reject    = w_key && ((r_state == TENS && !w_digit && !w_enter && !w_bksp) ||
                            (r_state == UNITS && !w_enter && !w_bksp));
  end
  // digit registers and registered pulses; bandera follows the LOAD cycle
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      r_dec  <= 8'h00;
      r_uni  <= 8'h00;
      r_band <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_band <= r_state == LOAD;
      r_err  <= w_reject || w_to_exp;
      if (w_to_exp) begin
        r_dec <= 8'h00;
        r_uni <= 8'h00;
      end else if (w_key) begin
        case (r_state)
          IDLE: if (w_digit) begin
            r_dec <= scan_code;
            r_uni <= 8'h00;
          end
          TENS: if (w_digit) r_uni <= scan_code;
            else if (w_enter) begin
              r_uni <= r_dec;
              r_dec <= 8'h45;
            end else if (w_bksp) r_dec <= 8'h00;
          UNITS: if (w_bksp) r_uni <= 8'h00;
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_temp_entry_ctrl.sv
// tb_temp_entry_ctrl: directed and randomized checks of temp_entry_ctrl against a digit-list reference model
module tb_temp_entry_ctrl;
`ifdef TEMP_ENTRY_TIMEOUT_EN
  localparam int T = 50;
`else
  localparam int T = 100_000_000;
`endif
  typedef logic [7:0] bq_t [$];
  logic CLK = 1'b0, reset = 1'b1, rx_done_tick = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic [7:0] decenas, unidades;
  logic bandera, busy, error;
  logic [1:0] digit_count;
  int tests = 0, fails = 0, band_cnt = 0, err_cnt = 0;
  int held, quiet;
  bit loading, brk, ext, m_band, m_err;
  logic [7:0] m_dec, m_uni;
  logic [7:0] dig_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  bq_t q;

  temp_entry_ctrl #(.TIMEOUT_CYCLES(T), .TO_W(27)) dut (
    .CLK(CLK), .reset(reset), .rx_done_tick(rx_done_tick), .scan_code(scan_code),
    .decenas(decenas), .unidades(unidades), .bandera(bandera), .busy(busy),
    .digit_count(digit_count), .error(error)
  );

  always #5 CLK = ~CLK;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_digit(logic [7:0] c);
    foreach (dig_tab[i]) if (dig_tab[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    held = 0; quiet = 0; loading = 0; brk = 0; ext = 0;
    m_band = 0; m_err = 0; m_dec = 8'h00; m_uni = 8'h00;
  endtask

  // held = number of digits collected; loading marks the cycle after a confirmed Enter
  task automatic model(bit v, logic [7:0] c);
    bit key, was_loading;
    m_band = loading;
    m_err = 0;
    was_loading = loading;
    loading = 0;
    key = 0;
    if (held > 0 && !v) begin
      quiet++;
`ifdef TEMP_ENTRY_TIMEOUT_EN
      if (quiet == T) begin
        held = 0; quiet = 0; m_err = 1; m_dec = 8'h00; m_uni = 8'h00;
      end
`endif
    end else quiet = 0;
    if (v) begin
      if (ext) ext = (c == 8'hF0);
      else if (brk) brk = 0;
      else if (c == 8'hF0) brk = 1;
      else if (c == 8'hE0) ext = 1;
      else key = 1;
    end
    if (key && !was_loading) begin
      if (held == 0) begin
        if (is_digit(c)) begin held = 1; m_dec = c; m_uni = 8'h00; end
      end else if (c == 8'h5A) begin
        if (held == 1) begin m_uni = m_dec; m_dec = 8'h45; end
        held = 0; loading = 1;
      end else if (c == 8'h66) begin
        if (held == 1) m_dec = 8'h00; else m_uni = 8'h00;
        held--;
      end else if (held == 1 && is_digit(c)) begin
        m_uni = c; held = 2;
      end else m_err = 1;
    end
  endtask

  task automatic compare_all(string tag);
    check({tag, ".decenas"}, decenas, m_dec);
    check({tag, ".unidades"}, unidades, m_uni);
    check({tag, ".bandera"}, bandera, m_band);
    check({tag, ".error"}, error, m_err);
    check({tag, ".busy"}, busy, held > 0);
    check({tag, ".digit_count"}, digit_count, held);
  endtask

  task automatic step(bit v, logic [7:0] c);
    rx_done_tick = v;
    scan_code = c;
    @(posedge CLK);
    #1;
    rx_done_tick = 1'b0;
    model(v, c);
    compare_all("step");
    band_cnt += bandera;
    err_cnt += error;
  endtask

  task automatic send(bq_t b);
    band_cnt = 0;
    err_cnt = 0;
    foreach (b[i]) begin
      step(1'b1, b[i]);
      step(1'b0, 8'h00);
    end
    step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    compare_all("reset_async");
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all("reset");
    @(negedge CLK);
    reset = 1'b0;
    q = '{8'h1E, 8'hF0, 8'h1E, 8'h2E, 8'hF0, 8'h2E, 8'h5A, 8'hF0, 8'h5A};
    send(q);
    check("two_digit.dec", decenas, 8'h1E);
    check("two_digit.uni", unidades, 8'h2E);
    check("two_digit.band", band_cnt, 1);
    check("two_digit.err", err_cnt, 0);
    q = '{8'h3D, 8'h5A};
    send(q);
    check("single.dec", decenas, 8'h45);
    check("single.uni", unidades, 8'h3D);
    check("single.band", band_cnt, 1);
    q = '{8'h26, 8'h36, 8'h66};
    send(q);
    check("bksp.uni", unidades, 8'h00);
    q = '{8'h16, 8'h5A};
    send(q);
    check("bksp.dec", decenas, 8'h26);
    check("bksp.uni2", unidades, 8'h16);
    check("bksp.band", band_cnt, 1);
    q = '{8'h16, 8'h1E, 8'h26};
    send(q);
    check("third.err", err_cnt, 1);
    check("third.uni", unidades, 8'h1E);
    q = '{8'h5A};
    send(q);
    check("third.band", band_cnt, 1);
    q = '{8'hE0, 8'h5A, 8'hF0, 8'h5A, 8'h5A};
    send(q);
    check("filt_idle.band", band_cnt, 0);
    check("filt_idle.err", err_cnt, 0);
    q = '{8'h16, 8'hE0, 8'h5A, 8'hF0, 8'h5A, 8'hE0, 8'hF0, 8'h5A};
    send(q);
    check("filt_tens.count", digit_count, 1);
    check("filt_tens.band", band_cnt, 0);
    check("filt_tens.err", err_cnt, 0);
    q = '{8'h66, 8'h25, 8'h46};
    send(q);
    check("pre_reset.count", digit_count, 2);
    do_reset();
    check("post_reset.dec", decenas, 8'h00);
`ifdef TEMP_ENTRY_TIMEOUT_EN
    step(1'b1, 8'h16);
    err_cnt = 0;
    repeat (49) step(1'b0, 8'h00);
    check("timeout.early", err_cnt, 0);
    step(1'b0, 8'h00);
    check("timeout.err", error, 1);
    check("timeout.busy", busy, 0);
    check("timeout.dec", decenas, 8'h00);
`endif
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r < 3) step(1'b0, 8'h00);
      else if (r < 6) step(1'b1, dig_tab[$urandom_range(0, 9)]);
      else if (r == 6) step(1'b1, 8'h5A);
      else if (r == 7) step(1'b1, 8'h66);
      else if (r == 8) step(1'b1, 8'hF0);
      else if (r == 9) step(1'b1, 8'hE0);
      else if (r == 10) step(1'b1, 8'($urandom));
      else if ($urandom_range(0, 15) == 0) repeat ($urandom_range(T > 60 ? 5 : T - 5, T > 60 ? 20 : T + 5)) step(1'b0, 8'h00);
      else step(1'b0, 8'h00);
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
